// File: rtl/sram8t_pkg.sv
// sram8t_pkg: shared types and defaults for the two-requester SRAM arbiter.
//   DefAddrWidth / DefDataWidth : default SRAM address and word widths
//   state_e                     : controller FSM states (idle, command, read wait)
package sram8t_pkg;

    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefDataWidth = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCmd    = 2'd1,
        StRdWait = 2'd2
    } state_e;

endpackage

// File: rtl/sram8t_rr_arb.sv
// sram8t_rr_arb: two-way round-robin grant with a priority pointer.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (priority returns to requester 0)
//   valid  in   [1:0] request present per requester
//   enable in   a grant may be issued this cycle
//   grant  out  [1:0] one-hot grant, zero when disabled or nothing is valid
// A grant is always taken by the requester it is issued to, so the pointer
// moves on every non-zero grant.
module sram8t_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    // Index of the requester that wins when both are valid.
    logic prio_q, prio_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // The requester not granted this time gets priority next time.
    always_comb begin
        prio_d = prio_q;
        if (|grant) begin
            prio_d = ~grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sram8t_arbiter.sv
// sram8t_arbiter: serialises two requesters onto one single-port SRAM with a
// registered read port. Writes complete in 2 cycles, reads in 3.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_valid/req_we [1:0]      per-requester request and op (1 = write)
//   req_addr0/1, req_wdata0/1   per-requester address and write data
//   req_ready [1:0]             one-hot accept strobe (only in idle)
//   rsp_valid/rsp_id/rsp_we     registered one-cycle completion pulse
//   rsp_rdata                   registered read data, held between reads
//   sram_cs/re/we, sram_addr, sram_din, sram_dout   SRAM interface
// Optional: define SRAM8T_ARB_STATS_EN to add stat_cnt0/stat_cnt1, saturating
// per-requester counts of accepted requests.
module sram8t_arbiter
    import sram8t_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            req_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_cs,
    output logic                  sram_re,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
`ifdef SRAM8T_ARB_STATS_EN
    ,
    output logic [15:0]           stat_cnt0,
    output logic [15:0]           stat_cnt1
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  we_q, we_d;
    logic                  id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  rsp_we_q, rsp_we_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0] grant;
    logic       sel;

    sram8t_rr_arb u_rr_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (req_valid),
        .enable (state_q == StIdle && !rst),
        .grant  (grant)
    );

    // Grants only go to valid requesters, so any grant is an acceptance.
    assign req_ready = grant;
    assign sel       = grant[1];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = we_q;
        id_d        = id_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    addr_d  = sel ? req_addr1 : req_addr0;
                    din_d   = sel ? req_wdata1 : req_wdata0;
                    we_d    = req_we[sel];
                    id_d    = sel;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (we_q) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b1;
                    rsp_id_d    = id_q;
                end else begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                // The only place sram_dout is sampled: it is driven here.
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_we_d    = 1'b0;
                rsp_id_d    = id_q;
                rsp_rdata_d = sram_dout;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign sram_cs   = (state_q == StCmd);
    assign sram_we   = sram_cs & we_q;
    assign sram_re   = sram_cs & ~we_q;
    assign sram_addr = addr_q;
    assign sram_din  = din_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef SRAM8T_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (grant[0] && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (grant[1] && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign stat_cnt0 = cnt0_q;
    assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_sram8t_arbiter.sv
// tb_sram8t_arbiter: bench for sram8t_arbiter with a registered-read SRAM
// model and a transaction-level reference (queues, latencies, round-robin rule).
// Define SRAM8T_ARB_STATS_EN to also check the statistics counters.
module tb_sram8t_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    req_valid, req_we, req_ready;
    logic [AW-1:0] req_addr0, req_addr1, sram_addr;
    logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, sram_din;
    logic          rsp_valid, rsp_id, rsp_we, sram_cs, sram_re, sram_we;
    wire  [DW-1:0] sram_dout;
`ifdef SRAM8T_ARB_STATS_EN
    logic [15:0]   stat_cnt0, stat_cnt1;
`endif

    sram8t_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_we     (rsp_we),
        .rsp_rdata  (rsp_rdata),
        .sram_cs    (sram_cs),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
`ifdef SRAM8T_ARB_STATS_EN
        ,
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1)
`endif
    );

    // SRAM model: read data appears for one cycle after the read strobe.
    logic [DW-1:0] sram_mem [16];
    logic [DW-1:0] sram_q;
    logic          sram_rd_q = 1'b0;
    always @(posedge clk) begin
        sram_rd_q <= sram_cs & sram_re;
        if (sram_cs & sram_re) sram_q <= sram_mem[sram_addr];
        if (sram_cs & sram_we) sram_mem[sram_addr] <= sram_din;
    end
    assign sram_dout = sram_rd_q ? sram_q : 'z;

    // Reference state
    op_t           q0[$], q1[$];
    logic [DW-1:0] ref_mem [16];
    int            cyc, idle_from, prio, cmd_cyc, rsp_cyc, st0, st1;
    logic          cmd_we, rsp_id_e, rsp_we_e;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_din, rsp_rdata_e, last_rdata, seen_rdata;
    int            dut_grants[$], dut_rsp_ids[$];
    int            n_checks, n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic drive();
        req_valid  = {q1.size() != 0, q0.size() != 0};
        req_we     = {q1.size() != 0 ? q1[0].we : 1'b0, q0.size() != 0 ? q0[0].we : 1'b0};
        req_addr0  = q0.size() != 0 ? q0[0].addr : '0;
        req_addr1  = q1.size() != 0 ? q1[0].addr : '0;
        req_wdata0 = q0.size() != 0 ? q0[0].data : '0;
        req_wdata1 = q1.size() != 0 ? q1[0].data : '0;
    endtask

    task automatic push(input int who, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        if (who == 0) q0.push_back(o); else q1.push_back(o);
        drive();
    endtask

    // One clock: check outputs at the falling edge, advance the model, then
    // redrive inputs just after the rising edge.
    task automatic step();
        logic [1:0] v, exp_ready;
        logic       exp_cs, exp_rv;
        op_t        e;
        int         g;
        @(negedge clk);
        v = {q1.size() != 0, q0.size() != 0};
        exp_ready = 2'b00;
        if (!rst && cyc >= idle_from && v != 2'b00)
            exp_ready = (v == 2'b11) ? (prio == 1 ? 2'b10 : 2'b01) : v;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (|(req_valid & req_ready)) dut_grants.push_back(req_ready[1] ? 1 : 0);

        exp_cs = (cyc == cmd_cyc);
        check("sram_cs", 32'(sram_cs), 32'(exp_cs));
        check("sram_we", 32'(sram_we), 32'(exp_cs & cmd_we));
        check("sram_re", 32'(sram_re), 32'(exp_cs & ~cmd_we));
        if (exp_cs) begin
            check("sram_addr", 32'(sram_addr), 32'(cmd_addr));
            if (cmd_we) check("sram_din", 32'(sram_din), 32'(cmd_din));
        end

        exp_rv = (cyc == rsp_cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (rsp_valid) begin
            dut_rsp_ids.push_back(rsp_id ? 1 : 0);
            if (!rsp_we) seen_rdata = rsp_rdata;
        end
        if (exp_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(rsp_id_e));
            check("rsp_we", 32'(rsp_we), 32'(rsp_we_e));
            if (!rsp_we_e) last_rdata = rsp_rdata_e;
        end
        check("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
        check("rsp_rdata_known", 32'($isunknown(rsp_rdata)), 32'd0);

        if (exp_ready != 2'b00) begin
            g = exp_ready[1] ? 1 : 0;
            if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
            cmd_cyc   = cyc + 1;
            cmd_we    = e.we;
            cmd_addr  = e.addr;
            cmd_din   = e.data;
            rsp_cyc   = cyc + (e.we ? 2 : 3);
            idle_from = rsp_cyc;
            rsp_id_e  = (g == 1);
            rsp_we_e  = e.we;
            if (e.we) ref_mem[e.addr] = e.data;
            else rsp_rdata_e = ref_mem[e.addr];
            prio = 1 - g;
            if (g == 0) st0++; else st1++;
        end
        if (rst) begin
            rsp_cyc = -1; cmd_cyc = -1; idle_from = cyc + 1; prio = 0;
            last_rdata = '0; st0 = 0; st1 = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cyc <= idle_from) && n < max_cycles) begin
            step();
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0 || cyc <= idle_from) check("drain_timeout", 1, 0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0; idle_from = 0; prio = 0; cmd_cyc = -1; rsp_cyc = -1;
        cmd_we = 1'b0; rsp_id_e = 1'b0; rsp_we_e = 1'b0; last_rdata = '0; st0 = 0; st1 = 0;

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_we", 32'(rsp_we), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_sram_cs", 32'(sram_cs), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_din", 32'(sram_din), 32'd0);
        step();

        // Requester 0 writes 0xA5 to address 3, then requester 1 reads it back.
        push(0, 1'b1, 4'd3, 8'hA5);
        drain(20);
        seen_rdata = '0;
        push(1, 1'b0, 4'd3, 8'h00);
        drain(20);
        check("rd_back_a5", 32'(seen_rdata), 32'hA5);

        // Fill the rest of memory, alternating requesters.
        for (int i = 0; i < 16; i++) begin
            if (i != 3) push(i % 2, 1'b1, 4'(i), 8'($urandom));
            else push(i % 2, 1'b0, 4'(i), 8'h00);
        end
        drain(80);

        // Both requesters with four back-to-back reads each.
        dut_grants.delete();
        dut_rsp_ids.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 4'($urandom_range(0, 15)), 8'h00);
            push(1, 1'b0, 4'($urandom_range(0, 15)), 8'h00);
        end
        drain(60);
        check("b2b_grants", 32'(dut_grants.size()), 32'd8);
        check("b2b_rsps", 32'(dut_rsp_ids.size()), 32'd8);
        for (int i = 0; i < 8 && i < dut_grants.size() && i < dut_rsp_ids.size(); i++) begin
            check("b2b_grant_order", 32'(dut_grants[i]), 32'(i % 2));
            check("b2b_rsp_order", 32'(dut_rsp_ids[i]), 32'(i % 2));
        end

        // Idle SRAM for ten cycles.
        repeat (10) step();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 3)
                push(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 3) == 0 && q1.size() < 3)
                push(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
            step();
        end
        drain(100);

        // Reset while a read from requester 0 sits in the read-wait state.
        push(0, 1'b0, 4'd5, 8'h00);
        for (int n = 0; n < 10 && !(!cmd_we && cyc == cmd_cyc + 1); n++) step();
        check("reached_rdwait", 32'(cyc == cmd_cyc + 1), 32'd1);
        dut_rsp_ids.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dut_grants.delete();
        push(1, 1'b1, 4'd6, 8'h3C);
        push(0, 1'b1, 4'd7, 8'hC3);
        drain(20);
        check("abort_rsp_count", 32'(dut_rsp_ids.size()), 32'd2);
        check("post_rst_grant0", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd0);

        // Statistics: five accepts on requester 0, two on requester 1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) push(0, 1'b1, 4'(i), 8'($urandom));
        for (int i = 0; i < 2; i++) push(1, 1'b0, 4'(i + 8), 8'h00);
        drain(60);
`ifdef SRAM8T_ARB_STATS_EN
        check("stat_cnt0", 32'(stat_cnt0), 32'd5);
        check("stat_cnt1", 32'(stat_cnt1), 32'd2);
        check("stat_cnt0_model", 32'(stat_cnt0), 32'(st0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
